// File: rtl/base_hps_pio_cmd_seq_if.sv
// rtl/base_hps_pio_cmd_seq_if.sv - PIO command / engine handshake / status bundle
interface base_hps_pio_cmd_seq_if;
   logic [7:0] pio_in;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [3:0] cmd_arg;
   logic       eng_done;
   logic [7:0] status_out;

   // HPS/engine side: drives the PIO word and engine responses
   modport master (
      output pio_in,
      output cmd_ready,
      output eng_done,
      input  cmd_valid,
      input  cmd_op,
      input  cmd_arg,
      input  status_out
   );

   // Sequencer side
   modport slave (
      input  pio_in,
      input  cmd_ready,
      input  eng_done,
      output cmd_valid,
      output cmd_op,
      output cmd_arg,
      output status_out
   );
endinterface

// File: rtl/base_hps_pio_cmd_seq.sv
// rtl/base_hps_pio_cmd_seq.sv - toggle-qualified PIO command sequencer with status word
module base_hps_pio_cmd_seq #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   base_hps_pio_cmd_seq_if.slave  bus
);

   localparam int TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_CLEAR = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_DONE      = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          tog_prev_q;
   logic          cmd_valid_q, cmd_valid_d;
   logic [2:0]    cmd_op_q, cmd_op_d;
   logic [3:0]    cmd_arg_q, cmd_arg_d;
   logic          ack_q, ack_d;
   logic          err_timeout_q, err_timeout_d;
   logic          err_overrun_q, err_overrun_d;
   logic [3:0]    done_cnt_q, done_cnt_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

   logic          tog_edge;
   logic          tmo_hit;
   logic [TW-1:0] tmo_next;

   assign tog_edge = bus.pio_in[7] ^ tog_prev_q;
   assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TMO_LAST);
   // With the timeout disabled the counter parks at all-ones instead of wrapping
   assign tmo_next = ((TIMEOUT_CYCLES == 0) && (&tmo_cnt_q)) ? tmo_cnt_q : tmo_cnt_q + TW'(1);

   // Next-state, command latch, error and status bookkeeping
   always_comb begin
      state_d       = state_q;
      cmd_valid_d   = cmd_valid_q;
      cmd_op_d      = cmd_op_q;
      cmd_arg_d     = cmd_arg_q;
      ack_d         = ack_q;
      err_timeout_d = err_timeout_q;
      err_overrun_d = err_overrun_q;
      done_cnt_d    = done_cnt_q;
      tmo_cnt_d     = tmo_cnt_q;

      // A toggle arriving while busy (including the DONE cycle) is dropped
      if (tog_edge && (state_q != ST_IDLE)) begin
         err_overrun_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (tog_edge) begin
               cmd_op_d  = bus.pio_in[6:4];
               cmd_arg_d = bus.pio_in[3:0];
               if (bus.pio_in[6:4] == OP_NOP) begin
                  state_d = ST_DONE;
               end else if (bus.pio_in[6:4] == OP_CLEAR) begin
                  err_timeout_d = 1'b0;
                  err_overrun_d = 1'b0;
                  state_d       = ST_DONE;
               end else begin
                  tmo_cnt_d   = '0;
                  cmd_valid_d = 1'b1;
                  state_d     = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            // eng_done is deliberately ignored until the command has been accepted
            if (bus.cmd_ready) begin
               cmd_valid_d = 1'b0;
               state_d     = ST_WAIT_DONE;
            end else if (tmo_hit) begin
               err_timeout_d = 1'b1;
               cmd_valid_d   = 1'b0;
               state_d       = ST_DONE;
            end else begin
               tmo_cnt_d = tmo_next;
            end
         end
         ST_WAIT_DONE: begin
            // Completion takes priority over a coincident timeout
            if (bus.eng_done) begin
               state_d = ST_DONE;
            end else if (tmo_hit) begin
               err_timeout_d = 1'b1;
               state_d       = ST_DONE;
            end else begin
               tmo_cnt_d = tmo_next;
            end
         end
         ST_DONE: begin
            ack_d      = ~ack_q;
            done_cnt_d = done_cnt_q + 4'd1;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register; toggle history follows pio_in even during reset
   always_ff @(posedge clk) begin
      tog_prev_q <= bus.pio_in[7];
      if (reset) begin
         state_q       <= ST_IDLE;
         cmd_valid_q   <= 1'b0;
         cmd_op_q      <= 3'd0;
         cmd_arg_q     <= 4'd0;
         ack_q         <= 1'b0;
         err_timeout_q <= 1'b0;
         err_overrun_q <= 1'b0;
         done_cnt_q    <= 4'd0;
         tmo_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         cmd_valid_q   <= cmd_valid_d;
         cmd_op_q      <= cmd_op_d;
         cmd_arg_q     <= cmd_arg_d;
         ack_q         <= ack_d;
         err_timeout_q <= err_timeout_d;
         err_overrun_q <= err_overrun_d;
         done_cnt_q    <= done_cnt_d;
         tmo_cnt_q     <= tmo_cnt_d;
      end
   end

   assign bus.cmd_valid  = cmd_valid_q;
   assign bus.cmd_op     = cmd_op_q;
   assign bus.cmd_arg    = cmd_arg_q;
   assign bus.status_out = {ack_q, (state_q != ST_IDLE), err_timeout_q, err_overrun_q, done_cnt_q};

endmodule
